// File: rtl/mul_io_sequencer_if.sv
// Byte-stream pins between the tile wrapper and the multiplier front-end.
interface mul_io_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Tile wrapper side: produces operand bytes, consumes product bytes
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Sequencer side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mul_io_sequencer.sv
// Byte-serial front-end for the pipelined multiplier: loads two operands,
// launches the core, waits for done under a watchdog, streams the product out.
module mul_io_sequencer #(
    parameter int unsigned OP_BYTES = 4,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    abort,
    mul_io_sequencer_if.slave       io,
    output logic                    busy,
    output logic                    err,
    output logic [8*OP_BYTES-1:0]   mul_a,
    output logic [8*OP_BYTES-1:0]   mul_b,
    output logic                    mul_start,
    input  logic                    mul_done,
    input  logic [16*OP_BYTES-1:0]  mul_p
);

    localparam int unsigned OP_W    = 8 * OP_BYTES;
    localparam int unsigned P_W     = 2 * OP_W;
    localparam int unsigned N_BYTES = 2 * OP_BYTES;
    localparam int unsigned BCNT_W  = $clog2(N_BYTES);

    typedef enum logic [2:0] {
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_SEND,
        S_ERR
    } state_e;

    state_e              state_q;
    logic [BCNT_W-1:0]   byte_cnt_q;
    logic [CNT_W-1:0]    wdog_q;
    logic [OP_W-1:0]     mul_a_q;
    logic [OP_W-1:0]     mul_b_q;
    logic [P_W-1:0]      prod_q;
    logic                mul_start_q;
    logic                out_valid_q;
    logic [7:0]          out_data_q;
    logic                busy_q;
    logic                err_q;
    logic                in_ready_q;

    logic                in_fire;
    logic                out_fire;
    logic [BCNT_W-1:0]   byte_cnt_inc;
    logic [7:0]          next_byte;

    // Handshakes only count while the block is clock-enabled
    assign in_fire      = io.in_valid & in_ready_q & ena;
    assign out_fire     = out_valid_q & io.out_ready & ena;
    assign byte_cnt_inc = byte_cnt_q + BCNT_W'(1);

    // Product byte presented after the current one is accepted
    always_comb begin
        next_byte = 8'h00;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            if (byte_cnt_inc == BCNT_W'(i)) begin
                next_byte = prod_q[8*i +: 8];
            end
        end
    end

    // Sequencer FSM with registered outputs; ena low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            byte_cnt_q  <= '0;
            wdog_q      <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            prod_q      <= '0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
        end else if (ena) begin
            if (abort) begin
                state_q     <= S_LOAD;
                byte_cnt_q  <= '0;
                wdog_q      <= '0;
                mul_start_q <= 1'b0;
                out_valid_q <= 1'b0;
                err_q       <= 1'b0;
                busy_q      <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        in_ready_q <= 1'b1;
                        if (in_fire) begin
                            for (int unsigned i = 0; i < OP_BYTES; i++) begin
                                if (byte_cnt_q == BCNT_W'(i)) begin
                                    mul_a_q[8*i +: 8] <= io.in_data;
                                end
                                if (byte_cnt_q == BCNT_W'(i + OP_BYTES)) begin
                                    mul_b_q[8*i +: 8] <= io.in_data;
                                end
                            end
                            if (byte_cnt_q == BCNT_W'(N_BYTES - 1)) begin
                                byte_cnt_q  <= '0;
                                in_ready_q  <= 1'b0;
                                mul_start_q <= 1'b1;
                                busy_q      <= 1'b1;
                                state_q     <= S_LAUNCH;
                            end else begin
                                byte_cnt_q <= byte_cnt_inc;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        mul_start_q <= 1'b0;
                        wdog_q      <= '0;
                        state_q     <= S_WAIT;
                    end
                    S_WAIT: begin
                        // done beats a watchdog expiry in the same cycle
                        if (mul_done) begin
                            prod_q      <= mul_p;
                            out_data_q  <= mul_p[7:0];
                            out_valid_q <= 1'b1;
                            byte_cnt_q  <= '0;
                            state_q     <= S_SEND;
                        end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_ERR;
                        end else begin
                            wdog_q <= wdog_q + CNT_W'(1);
                        end
                    end
                    S_SEND: begin
                        if (out_fire) begin
                            if (byte_cnt_q == BCNT_W'(N_BYTES - 1)) begin
                                byte_cnt_q  <= '0;
                                out_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                                in_ready_q  <= 1'b1;
                                state_q     <= S_LOAD;
                            end else begin
                                byte_cnt_q <= byte_cnt_inc;
                                out_data_q <= next_byte;
                            end
                        end
                    end
                    S_ERR: begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                    default: begin
                        state_q <= S_LOAD;
                    end
                endcase
            end
        end
    end

    // in_ready and the start pulse are masked by ena without disturbing state
    assign io.in_ready  = in_ready_q & ena;
    assign mul_start    = mul_start_q & ena;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;

endmodule

// File: tb/tb_mul_io_sequencer.sv
// Self-checking bench for mul_io_sequencer: operands go in byte-wise, the
// expected product stream comes from plain 64-bit multiplication.
module tb_mul_io_sequencer;

    localparam int unsigned OP_BYTES = 4;
    localparam int unsigned TIMEOUT  = 64;
    localparam int unsigned CNT_W    = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        abort;
    logic        busy;
    logic        err;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_start;
    logic        mul_done;
    logic [63:0] mul_p;

    int vectors     = 0;
    int miscompares = 0;

    mul_io_sequencer_if io();

    mul_io_sequencer #(
        .OP_BYTES (OP_BYTES),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .abort     (abort),
        .io        (io),
        .busy      (busy),
        .err       (err),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_p     (mul_p)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer n operand bytes (A little-endian then B), waiting on in_ready
    task automatic send_bytes(input logic [31:0] a, input logic [31:0] b, input int n);
        logic [63:0] word;
        int guard;
        word = {b, a};
        for (int k = 0; k < n; k++) begin
            io.in_data  = word[8*k +: 8];
            io.in_valid = 1'b1;
            guard = 0;
            while (io.in_ready !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (io.in_ready !== 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL load_ready byte%0d: in_ready=%b, required 1", k, io.in_ready);
                break;
            end
            tick();
        end
        io.in_valid = 1'b0;
        io.in_data  = 8'h00;
    endtask

    // Full transaction: load, done after 'delay' cycles, drain with a ready pattern
    task automatic do_txn(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int delay, input int mode, input bit gap);
        logic [63:0] prod;
        logic [7:0]  exp_b;
        int          idx;
        int          cyc;
        bit          rdy;
        bit          gap_done;
        prod = 64'(a) * 64'(b);
        send_bytes(a, b, 8);
        vectors++;
        if (mul_start !== 1'b1 || busy !== 1'b1 || mul_a !== a || mul_b !== b) begin
            miscompares++;
            $display("FAIL %s launch: start=%b busy=%b a=%h b=%h, required 1 1 %h %h",
                     name, mul_start, busy, mul_a, mul_b, a, b);
        end
        for (int d = 1; d <= delay; d++) begin
            tick();
            vectors++;
            if (mul_start !== 1'b0 || busy !== 1'b1 || io.out_valid !== 1'b0 || err !== 1'b0 ||
                mul_a !== a || mul_b !== b) begin
                miscompares++;
                $display("FAIL %s wait%0d: start=%b busy=%b valid=%b err=%b a=%h b=%h, required 0 1 0 0 %h %h",
                         name, d, mul_start, busy, io.out_valid, err, mul_a, mul_b, a, b);
            end
        end
        mul_done = 1'b1;
        mul_p    = prod;
        tick();
        mul_done = 1'b0;
        mul_p    = {$urandom(), $urandom()};
        idx = 0;
        cyc = 0;
        gap_done = 1'b0;
        while (idx < 8 && cyc < 200) begin
            exp_b = 8'(prod >> (8 * idx));
            vectors++;
            if (io.out_valid !== 1'b1 || io.out_data !== exp_b || busy !== 1'b1 ||
                err !== 1'b0 || mul_start !== 1'b0) begin
                miscompares++;
                $display("FAIL %s byte%0d: valid=%b data=%h busy=%b err=%b start=%b, required 1 %h 1 0 0",
                         name, idx, io.out_valid, io.out_data, busy, err, mul_start, exp_b);
            end
            if (gap && idx == 3 && !gap_done) begin
                gap_done     = 1'b1;
                ena          = 1'b0;
                io.out_ready = 1'b1;
                for (int g = 0; g < 10; g++) begin
                    tick();
                    vectors++;
                    if (io.out_valid !== 1'b1 || io.out_data !== exp_b || io.in_ready !== 1'b0 ||
                        busy !== 1'b1 || mul_start !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s ena_hold%0d: valid=%b data=%h in_ready=%b busy=%b, required 1 %h 0 1",
                                 name, g, io.out_valid, io.out_data, io.in_ready, busy, exp_b);
                    end
                end
                ena = 1'b1;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            io.out_ready = rdy;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        io.out_ready = 1'b0;
        vectors++;
        if (idx != 8 || io.out_valid !== 1'b0 || busy !== 1'b0 || io.in_ready !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: handshakes=%0d valid=%b busy=%b in_ready=%b err=%b, required 8 0 0 1 0",
                     name, idx, io.out_valid, busy, io.in_ready, err);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        ena          = 1'b1;
        abort        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_data   = 8'h00;
        io.out_ready = 1'b0;
        mul_done     = 1'b0;
        mul_p        = 64'h0;
        repeat (3) tick();
        vectors++;
        if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0 || io.out_data !== 8'h00 || busy !== 1'b0 ||
            err !== 1'b0 || mul_start !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: in_ready=%b valid=%b data=%h busy=%b err=%b start=%b a=%h b=%h, required all 0",
                     io.in_ready, io.out_valid, io.out_data, busy, err, mul_start, mul_a, mul_b);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (io.in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", io.in_ready, busy);
        end
    endtask

    task automatic test_basic();
        do_txn("basic", 32'h3, 32'h5, 4, 0, 1'b0);
    endtask

    task automatic test_max_operands();
        do_txn("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_txn("backpressure", $urandom(), $urandom(), 1, 1, 1'b0);
    endtask

    task automatic test_timeout();
        send_bytes($urandom(), $urandom(), 8);
        vectors++;
        if (mul_start !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_launch: start=%b, required 1", mul_start);
        end
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            vectors++;
            if (err !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout_early%0d: err=%b busy=%b, required 0 1", k, err, busy);
            end
        end
        tick();
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || io.in_ready !== 1'b0 || io.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_err: err=%b busy=%b in_ready=%b valid=%b, required 1 0 0 0",
                     err, busy, io.in_ready, io.out_valid);
        end
        mul_done = 1'b1;
        mul_p    = {$urandom(), $urandom()};
        tick();
        mul_done = 1'b0;
        repeat (3) tick();
        vectors++;
        if (err !== 1'b1 || io.out_valid !== 1'b0 || io.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_sticky: err=%b valid=%b in_ready=%b, required 1 0 0", err, io.out_valid, io.in_ready);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (err !== 1'b0 || io.in_ready !== 1'b1 || busy !== 1'b0 || io.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_recover: err=%b in_ready=%b busy=%b valid=%b, required 0 1 0 0",
                     err, io.in_ready, busy, io.out_valid);
        end
        do_txn("post_abort", $urandom(), $urandom(), 3, 0, 1'b0);
    endtask

    task automatic test_collision();
        do_txn("collision", $urandom(), $urandom(), TIMEOUT, 0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] a;
        a = $urandom() | 32'h1;
        send_bytes(a, $urandom(), 5);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (io.in_ready !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0 || busy !== 1'b0 ||
            io.out_valid !== 1'b0 || err !== 1'b0 || mul_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: in_ready=%b a=%h b=%h busy=%b valid=%b err=%b start=%b, required all 0",
                     io.in_ready, mul_a, mul_b, busy, io.out_valid, err, mul_start);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_txn("after_reset", $urandom(), $urandom(), 2, 0, 1'b0);
    endtask

    task automatic test_ena_gap();
        do_txn("ena_gap", $urandom(), $urandom(), 5, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            // A stray done while loading must not disturb anything
            mul_done = 1'b1;
            mul_p    = {$urandom(), $urandom()};
            tick();
            mul_done = 1'b0;
            vectors++;
            if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL stray_done%0d: valid=%b in_ready=%b busy=%b, required 0 1 0",
                         t, io.out_valid, io.in_ready, busy);
            end
            do_txn("random", $urandom(), $urandom(), int'($urandom_range(1, TIMEOUT)), 2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_operands();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid_load();
        test_ena_gap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus itself ever stalls
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/mul_io_sequencer.md
Name: mul_io_sequencer

Overview:
Byte-serial front-end controller for the 32-bit pipelined multiplier.
- Collects two 32-bit operands over an 8-bit input bus.
- Issues a single start pulse to the multiplier datapath and waits for its done strobe, guarded by a watchdog.
- Streams the 64-bit product back out one byte at a time with valid/ready backpressure.
- Sits between the tile pin wrapper and the multiplier core.

Parameters:
- OP_BYTES, 4: bytes per operand; operand width is 8*OP_BYTES.
- TIMEOUT, 64: maximum cycles spent in WAIT before entering ERR; must be at least 2.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock-enable; when low, all state, counters and registered outputs hold
- abort  in  1  synchronous abort; returns the block to LOAD from any state
- in_data  in  8  operand byte
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block accepts a byte this cycle
- out_data  out  8  product byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in LAUNCH, WAIT and SEND
- err  out  1  sticky watchdog error flag
- mul_a  out  32  operand A to the multiplier, registered
- mul_b  out  32  operand B to the multiplier, registered
- mul_start  out  1  one-cycle start pulse
- mul_done  in  1  product-valid strobe from the multiplier
- mul_p  in  64  product from the multiplier

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=LOAD, byte_cnt=0, wdog=0.
  - mul_a=0, mul_b=0, prod_reg=0.
  - mul_start=0, out_valid=0, out_data=0, busy=0, err=0, in_ready=0.
- Asserting rst_n mid-operation discards all partial operands and results.
- States: LOAD → LAUNCH → WAIT → SEND → LOAD, plus ERR.
- LOAD:
  - in_ready=1 (registered, becomes 1 the cycle after reset release).
  - A byte is accepted when in_valid & in_ready & ena.
  - Bytes 0–3 fill mul_a little-endian: byte0 goes to mul_a[7:0].
  - Bytes 4–7 fill mul_b in the same order.
  - The 8th accepted byte moves the state to LAUNCH.
- LAUNCH:
  - mul_start=1 for exactly one cycle; next state is WAIT.
  - wdog clears to 0.
  - mul_a and mul_b are stable from LAUNCH until the next LOAD begins.
- WAIT:
  - wdog increments every enabled cycle.
  - mul_done=1: latch mul_p into prod_reg, byte_cnt=0, go to SEND.
  - wdog reaching TIMEOUT-1 without mul_done: go to ERR and set err=1.
  - If mul_done and the timeout expiry fall in the same cycle, mul_done wins.
- mul_done in any state other than WAIT is ignored.
- SEND:
  - out_valid=1 and out_data=prod_reg[8*byte_cnt +: 8], LSB first.
  - byte_cnt advances only on out_valid & out_ready.
  - While out_ready=0, out_data and out_valid hold.
  - The handshake on byte 7 returns the state to LOAD with byte_cnt=0 and out_valid=0 the next cycle.
- ERR:
  - out_valid=0, in_ready=0, busy=0.
  - Exits only on abort or reset.
- abort=1 (takes effect only when ena=1):
  - Next state is LOAD; byte_cnt=0, wdog=0.
  - mul_start, out_valid and err are cleared; mul_a, mul_b and prod_reg hold.
  - abort has priority over every other transition.
- ena=0:
  - No byte is accepted and in_ready=0 combinationally.
  - No handshake occurs; mul_start is forced to 0 and a pending pulse is deferred until ena=1.
  - wdog does not count.
- Latency:
  - 8th input byte accepted → mul_start high on the next cycle.
  - mul_done high → first out_valid on the next cycle.
- The multiplier pipeline depth is opaque to this block.

Test Plan:
- Basic multiply:
  - Stimulus: feed bytes 03 00 00 00 05 00 00 00 with in_valid held high and mul_done modelled 4 cycles after mul_start.
  - Required response: mul_a=0x3, mul_b=0x5, exactly one mul_start pulse, and out bytes 0F 00 00 00 00 00 00 00.
- Maximum operands:
  - Stimulus: A=B=0xFFFFFFFF.
  - Required response: output bytes 01 00 00 00 FE FF FF FF; busy high from LAUNCH through the last handshake.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... during SEND.
  - Required response: no byte is duplicated or dropped; out_data is stable while out_ready=0; exactly 8 handshakes.
- Watchdog timeout:
  - Stimulus: never assert mul_done.
  - Required response: err=1 exactly TIMEOUT cycles after entering WAIT.
  - Stimulus: then pulse abort.
  - Required response: state returns to LOAD, err=0, in_ready=1.
- Done/timeout collision:
  - Stimulus: assert mul_done in the same cycle wdog reaches TIMEOUT-1.
  - Required response: state goes to SEND, err stays 0.
- Reset and enable:
  - Stimulus: drop rst_n after 5 loaded bytes.
  - Required response: all outputs return to their reset values immediately; a fresh 8-byte load then succeeds.
  - Stimulus: hold ena=0 for 10 cycles mid-SEND.
  - Required response: no state change and no handshakes during those cycles; byte sequence unchanged after ena returns.
